// File: rtl/instr_encoder_pkg.sv
// ----------------------------------------------------------------------------
// instr_encoder_pkg
//   Shared definitions for the 9-bit ISA. The control decoder uses the same
//   package, so opcode codes and word widths stay consistent between the
//   encoder and the decoder.
//   Contents:
//     OPW, MCODEBITS  - opcode width and machine word width
//     op_t            - opcode enum (instr[8:6])
//     state_t         - encoder FSM state, also exported for debug
//     is_imm_op()     - true for opcodes whose second operand is an immediate
// ----------------------------------------------------------------------------
package instr_encoder_pkg;

    localparam int OPW       = 3;
    localparam int MCODEBITS = 9;

    typedef enum logic [OPW-1:0] {
        OP_AND   = 3'b000,
        OP_ADD   = 3'b001,
        OP_XOR   = 3'b010,
        OP_BNE   = 3'b011,
        OP_LS    = 3'b100,
        OP_RS    = 3'b101,
        OP_LOAD  = 3'b110,
        OP_STORE = 3'b111
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FULL = 2'd2
    } state_t;

    // add takes a signed immediate; ls/rs take an unsigned shift amount.
    function automatic logic is_imm_op(op_t op);
        return (op == OP_ADD) || (op == OP_LS) || (op == OP_RS);
    endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// ----------------------------------------------------------------------------
// instr_encoder_if
//   Request stream into the encoder plus its instruction-memory write port.
//
//   Handshake: the source holds in_valid and the payload (in_op, in_ra,
//   in_rb) stable until a rising clock edge at which in_valid & in_ready are
//   both 1; that edge transfers exactly one request. in_ready may depend
//   combinationally on the encoder's start input but never on in_valid.
//
//   Write port: im_we is a one-cycle pulse per written word; im_addr and
//   im_wdata are registered and hold their last values while im_we is 0.
//
//   Modports: master = request source / memory sink, slave = encoder.
// ----------------------------------------------------------------------------
interface instr_encoder_if
    import instr_encoder_pkg::*;
#(
    parameter int PCW = 8
) ();

    logic                 in_valid;
    logic                 in_ready;
    op_t                  in_op;
    logic [3:0]           in_ra;
    logic [7:0]           in_rb;

    logic                 im_we;
    logic [PCW-1:0]       im_addr;
    logic [MCODEBITS-1:0] im_wdata;

    modport master (
        output in_valid, in_op, in_ra, in_rb,
        input  in_ready, im_we, im_addr, im_wdata
    );

    modport slave (
        input  in_valid, in_op, in_ra, in_rb,
        output in_ready, im_we, im_addr, im_wdata
    );

endinterface

// File: rtl/instr_encoder_packer.sv
// ----------------------------------------------------------------------------
// instr_field_packer
//   Combinational: packs one request into a machine word and flags whether it
//   is encodable.
//   Ports:
//     op    in   opcode
//     ra    in   first register index (4 bits, only 0..7 encodable)
//     rb    in   second register index or immediate (8 bits)
//     word  out  {op, ra[2:0], rb[2:0]}
//     legal out  1 when the request fits the 3-bit fields
// ----------------------------------------------------------------------------
module instr_field_packer
    import instr_encoder_pkg::*;
(
    input  op_t                  op,
    input  logic [3:0]           ra,
    input  logic [7:0]           rb,
    output logic [MCODEBITS-1:0] word,
    output logic                 legal
);

    logic rb_ok;

    always_comb begin
        word  = {op, ra[2:0], rb[2:0]};
        rb_ok = 1'b0;
        if (is_imm_op(op) && (op == OP_ADD)) begin
            // Signed -4..3: bits [7:2] must be a pure sign extension of bit 2.
            rb_ok = (rb[7:2] == 6'b111111) || (rb[7:2] == 6'b000000);
        end else begin
            // Register index or unsigned shift amount: 0..7.
            rb_ok = (rb[7:3] == 5'b00000);
        end
        legal = ~ra[3] & rb_ok;
    end

endmodule

// File: rtl/instr_encoder.sv
// ----------------------------------------------------------------------------
// instr_encoder
//   Accepts {op, ra, rb} requests and writes the encoded 9-bit words into
//   instruction memory at consecutive addresses starting from 0.
//   Ports:
//     Clk       in   clock, rising edge
//     Reset     in   asynchronous active-high reset
//     start     in   restart at address 0, clear count and error capture
//     bus       slave request stream + instruction-memory write port
//     count     out  words written since start (PCW+1 bits)
//     full      out  all 2**PCW words written
//     err       out  sticky: some request was dropped as unencodable
//     err_addr  out  address the first dropped request would have taken
//     dbg_state out  current FSM state
// ----------------------------------------------------------------------------
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int PCW = 8
) (
    input  logic           Clk,
    input  logic           Reset,
    input  logic           start,
    instr_encoder_if.slave bus,
    output logic [PCW:0]   count,
    output logic           full,
    output logic           err,
    output logic [PCW-1:0] err_addr,
    output state_t         dbg_state
);

    localparam logic [PCW-1:0] LAST_ADDR = {PCW{1'b1}};

    state_t               state;
    state_t               state_n;
    logic [PCW-1:0]       wptr;
    logic                 ready;
    logic                 accept;
    logic                 write_en;
    logic                 drop;
    logic [MCODEBITS-1:0] word;
    logic                 legal;

    logic                 we_q;
    logic [PCW-1:0]       addr_q;
    logic [MCODEBITS-1:0] wdata_q;

    instr_field_packer u_packer (
        .op    (bus.in_op),
        .ra    (bus.in_ra),
        .rb    (bus.in_rb),
        .word  (word),
        .legal (legal)
    );

    // start wins over a simultaneous request: nothing is transferred that cycle.
    assign ready    = (state == S_RUN) & ~start;
    assign accept   = bus.in_valid & ready;
    assign write_en = accept & legal;
    assign drop     = accept & ~legal;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        if (start) begin
            state_n = S_RUN;
        end else if (write_en && (wptr == LAST_ADDR)) begin
            // Only a written word fills the last slot; a dropped request there
            // leaves the encoder running.
            state_n = S_FULL;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            wptr     <= '0;
            count    <= '0;
            err      <= 1'b0;
            err_addr <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            we_q <= write_en;
            if (write_en) begin
                addr_q  <= wptr;
                wdata_q <= word;
            end
            if (start) begin
                wptr     <= '0;
                count    <= '0;
                err      <= 1'b0;
                err_addr <= '0;
            end else if (write_en) begin
                // Wraps to 0 only on the final word, after which FULL blocks input.
                wptr  <= wptr + 1'b1;
                count <= count + 1'b1;
            end else if (drop && !err) begin
                err      <= 1'b1;
                err_addr <= wptr;
            end
        end
    end

    assign bus.in_ready = ready;
    assign bus.im_we    = we_q;
    assign bus.im_addr  = addr_q;
    assign bus.im_wdata = wdata_q;
    assign full         = (state == S_FULL);
    assign dbg_state    = state;

endmodule
